// File: rtl/vga_output_ctrl.sv
// vga_output_ctrl: 640x480@60 VGA timing, frame-buffer addressing and shift/mux/sync control.
// Optional macro TEST_PATTERN_EN adds a test_mode input that selects the test pattern.
module vga_output_ctrl #(
    parameter int DIV    = 6,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
`ifdef TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic              pixelclk,
    output logic              pixel_clk,
    output logic [9:0]        colcount,
    output logic [9:0]        rowcount,
    output logic [ADDR_W-1:0] addrcount,
    output logic              flag_addr,
    output logic              coltimerenable,
    output logic              rowtimerenable,
    output logic              shift1load,
    output logic              shift2load,
    output logic              shiftmux_delay,
    output logic [1:0]        outputmuxsel,
    output logic              n_vsync_delay,
    output logic              n_hsync_delay
);
    localparam int DW       = $clog2(DIV);
    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int VS_START = V_VIS + V_FP;
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_VIS * V_VIS - 1);

    logic [DW-1:0]     div_q, div_d;
    logic [9:0]        col_q, col_d, row_q, row_d, next_row;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              smux_q, smux_d, vs_q, vs_d, hs_q, hs_d;
    logic [1:0]        msel_q, msel_d;
    logic              tm, col_end, row_end, vis, load_ok, mid_load, wrap_load;

`ifdef TEST_PATTERN_EN
    assign tm = test_mode;
`else
    assign tm = 1'b0;
`endif

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            div_q  <= '0;
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            smux_q <= 1'b0;
            msel_q <= 2'b00;
            vs_q   <= 1'b1;
            hs_q   <= 1'b1;
        end else begin
            div_q  <= div_d;
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
            smux_q <= smux_d;
            msel_q <= msel_d;
            vs_q   <= vs_d;
            hs_q   <= hs_d;
        end
    end

    always_comb begin
        pixelclk = enable && div_q == DW'(DIV - 1);
        col_end  = col_q == 10'(H_TOT - 1);
        row_end  = row_q == 10'(V_TOT - 1);
        next_row = row_end ? 10'd0 : row_q + 10'd1;
        vis      = col_q < 10'(H_VIS) && row_q < 10'(V_VIS);
        div_d    = !enable ? div_q : (div_q == DW'(DIV - 1) ? '0 : div_q + 1'b1);
        col_d    = !pixelclk ? col_q : (col_end ? 10'd0 : col_q + 10'd1);
        row_d    = pixelclk && col_end ? next_row : row_q;
        addr_d   = !pixelclk ? addr_q :
                   (col_end && row_end) ? '0 :
                   (vis && addr_q != ADDR_MAX) ? addr_q + 1'b1 : addr_q;
        // Sync, mux and select registers describe the pixel just left, hence one pixel behind
        smux_d   = pixelclk ? vis && col_q[3] : smux_q;
        msel_d   = !pixelclk ? msel_q : (vis ? (tm ? 2'b10 : 2'b01) : 2'b00);
        hs_d     = pixelclk ? !(col_q >= 10'(HS_START) && col_q < 10'(HS_START + H_SYNC)) : hs_q;
        vs_d     = pixelclk ? !(row_q >= 10'(VS_START) && row_q < 10'(VS_START + V_SYNC)) : vs_q;
        // Each group is loaded one group ahead; group 0 comes from the tail of the previous line
        load_ok   = pixelclk && !tm;
        mid_load  = load_ok && row_q < 10'(V_VIS) && col_q[2:0] == 3'd0 && col_q < 10'(H_VIS - 8);
        wrap_load = load_ok && col_q == 10'(H_TOT - 8) && next_row < 10'(V_VIS);
    end

    assign pixel_clk      = div_q < DW'(DIV / 2);
    assign colcount       = col_q;
    assign rowcount       = row_q;
    assign addrcount      = addr_q;
    assign flag_addr      = pixelclk && vis && addr_q == ADDR_MAX;
    assign coltimerenable = pixelclk;
    assign rowtimerenable = pixelclk && col_end;
    assign shift1load     = (mid_load && col_q[3]) || wrap_load;
    assign shift2load     = mid_load && !col_q[3];
    assign shiftmux_delay = smux_q;
    assign outputmuxsel   = msel_q;
    assign n_vsync_delay  = vs_q;
    assign n_hsync_delay  = hs_q;
endmodule

// File: tb/tb_vga_output_ctrl.sv
// tb_vga_output_ctrl: scoreboard bench for vga_output_ctrl on a scaled-down raster.
// Expected outputs come from a position model derived from the count of enabled clocks.
module tb_vga_output_ctrl;
    localparam int DIV = 6, H_VIS = 32, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_VIS = 6, V_FP = 2, V_SYNC = 2, V_BP = 2, ADDR_W = 19;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FTOT  = H_TOT * V_TOT;
    localparam int AMAX  = H_VIS * V_VIS - 1;

    typedef struct {
        int pclk, pxclk, col, row, addr, flag, rowten, s1, s2, smux, msel, vs, hs;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b1;
    logic pixelclk, pixel_clk, flag_addr, coltimerenable, rowtimerenable;
    logic shift1load, shift2load, shiftmux_delay, n_vsync_delay, n_hsync_delay;
    logic [9:0] colcount, rowcount;
    logic [ADDR_W-1:0] addrcount;
    logic [1:0] outputmuxsel;
    int n_chk = 0, n_pass = 0, n = 0;
    exp_t q[$];

    vga_output_ctrl #(
        .DIV(DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .n_rst(rst), .enable(enable),
`ifdef TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .pixelclk(pixelclk), .pixel_clk(pixel_clk), .colcount(colcount), .rowcount(rowcount),
        .addrcount(addrcount), .flag_addr(flag_addr), .coltimerenable(coltimerenable),
        .rowtimerenable(rowtimerenable), .shift1load(shift1load), .shift2load(shift2load),
        .shiftmux_delay(shiftmux_delay), .outputmuxsel(outputmuxsel),
        .n_vsync_delay(n_vsync_delay), .n_hsync_delay(n_hsync_delay)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    endtask

    // Position-based model: n enabled clocks since release -> n/DIV strobes -> raster position
    function automatic exp_t model(int cnt, int e);
        exp_t x;
        int s, pos, col, row, a, pp, pc, pr, tp, tc, tr, vp;
        s = cnt / DIV;
        pos = s % FTOT;
        col = pos % H_TOT;
        row = pos / H_TOT;
        x.pclk = (e != 0 && cnt % DIV == DIV - 1) ? 1 : 0;
        x.pxclk = (cnt % DIV < DIV / 2) ? 1 : 0;
        x.col = col;
        x.row = row;
        a = (row < V_VIS) ? row * H_VIS + (col < H_VIS ? col : H_VIS) : V_VIS * H_VIS;
        x.addr = a > AMAX ? AMAX : a;
        x.flag = (x.pclk == 1 && pos == (V_VIS - 1) * H_TOT + H_VIS - 1) ? 1 : 0;
        x.rowten = (x.pclk == 1 && col == H_TOT - 1) ? 1 : 0;
        tp = (pos + 8) % FTOT;
        tc = tp % H_TOT;
        tr = tp / H_TOT;
        x.s1 = (x.pclk == 1 && tc % 8 == 0 && tc < H_VIS && tr < V_VIS && (tc / 8) % 2 == 0) ? 1 : 0;
        x.s2 = (x.pclk == 1 && tc % 8 == 0 && tc < H_VIS && tr < V_VIS && (tc / 8) % 2 == 1) ? 1 : 0;
        if (s == 0) begin
            x.smux = 0; x.msel = 0; x.vs = 1; x.hs = 1;
        end else begin
            pp = (s - 1) % FTOT;
            pc = pp % H_TOT;
            pr = pp / H_TOT;
            vp = (pc < H_VIS && pr < V_VIS) ? 1 : 0;
            x.msel = vp;
            x.smux = (vp == 1 && (pc / 8) % 2 == 1) ? 1 : 0;
            x.hs = (pc >= H_VIS + H_FP && pc < H_VIS + H_FP + H_SYNC) ? 0 : 1;
            x.vs = (pr >= V_VIS + V_FP && pr < V_VIS + V_FP + V_SYNC) ? 0 : 1;
        end
        return x;
    endfunction

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        enable = e;
        if (r) n = 0;
        else if (e) n++;
        q.push_back(model(n, int'(e)));
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("pixelclk", pixelclk, x.pclk);
                check("coltimerenable", coltimerenable, x.pclk);
                check("pixel_clk", pixel_clk, x.pxclk);
                check("colcount", colcount, x.col);
                check("rowcount", rowcount, x.row);
                check("addrcount", addrcount, x.addr);
                check("flag_addr", flag_addr, x.flag);
                check("rowtimerenable", rowtimerenable, x.rowten);
                check("shift1load", shift1load, x.s1);
                check("shift2load", shift2load, x.s2);
                check("shiftmux_delay", shiftmux_delay, x.smux);
                check("outputmuxsel", outputmuxsel, x.msel);
                check("n_vsync_delay", n_vsync_delay, x.vs);
                check("n_hsync_delay", n_hsync_delay, x.hs);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 4000; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) step(1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_col", colcount, 0);
        check("async_row", rowcount, 0);
        check("async_hsync", n_hsync_delay, 1);
        check("async_addr", addrcount, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 1500; i++) step(1'b0, 1'b1);
        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_output_ctrl.md
Name: vga_output_ctrl

Overview:
VGA 640x480@60 Hz output controller for the display pipeline, running on a single 150 MHz system clock. Contains:
- a pixel-rate strobe divider;
- column, row and frame-buffer address counters;
- output control logic driving the pixel shift registers, the shift/output muxes and the sync lines.

It sits between frame-buffer read logic (which uses the address and load strobes) and the DAC/pin output stage.

Parameters:
DIV, 6, system clocks per pixel (150 MHz / 6 = 25 MHz)
H_VIS, 640, visible columns
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); line total 800
V_VIS, 480, visible rows
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); frame total 525
ADDR_W, 19, address counter width

Ports:
clk  in  1  system clock, 150 MHz, all logic on rising edge
n_rst  in  1  asynchronous reset, active-HIGH (1 = reset) despite the codebase name
enable  in  1  1 = timing runs; 0 = all counters hold, outputs hold
pixelclk  out  1  one-clk strobe per pixel: high when divider count == DIV-1
pixel_clk  out  1  25 MHz square-wave: high for divider counts 0..2
colcount  out  10  current column 0..799
rowcount  out  10  current row 0..524
addrcount  out  ADDR_W  frame-buffer pixel address 0..307199
flag_addr  out  1  one-clk pulse on the strobe where addrcount == 307199
coltimerenable  out  1  equals pixelclk
rowtimerenable  out  1  pixelclk && colcount == 799
shift1load  out  1  one-clk load pulse for shift register A
shift2load  out  1  one-clk load pulse for shift register B
shiftmux_delay  out  1  0 = select register A, 1 = select register B
outputmuxsel  out  2  00 = blank (black), 01 = shift data, 10 = test pattern, 11 = reserved (never driven)
n_vsync_delay  out  1  active-low vertical sync, pipeline-delayed
n_hsync_delay  out  1  active-low horizontal sync, pipeline-delayed

Behaviour:
- Reset (async, n_rst = 1): divider, colcount, rowcount and addrcount = 0; all pulses = 0; shiftmux_delay = 0; outputmuxsel = 00; n_vsync_delay = 1; n_hsync_delay = 1. Same values for a mid-frame reset.
- After release: first pixelclk 6 clks later; counting restarts at row 0, col 0.
- Divider: 0..DIV-1, wraps to 0.
- Counter updates occur only on a pixelclk clock edge:
  - col increments and wraps 799 -> 0;
  - on col wrap, row increments and wraps 524 -> 0;
  - row = 524 and col = 799 simultaneously: both wrap to 0.
- Visible region: col < 640 && row < 480.
- addrcount:
  - increments on each pixelclk in the visible region;
  - saturates at 307199 (flag_addr pulses on that strobe);
  - returns to 0 on the strobe where row wraps to 0.
- All registered outputs below update on pixelclk edges, computed from the pre-increment counter values. They therefore lag the counters by one pixel.
- n_hsync_delay = 0 when col in 656..751.
- n_vsync_delay = 0 when row in 490..491.
- outputmuxsel = 01 when visible, else 00.
- Pixel groups: g = col >> 3 (8 pixels each). Group g is served by register A if g is even, B if g is odd.
  - shiftmux_delay = registered col[3] during visible; held at 0 otherwise.
- Load pulses (single clk, coincident with pixelclk):
  - group g >= 1 is loaded at col == 8g-8 (one group ahead);
  - group 0 is loaded at col == 792 of the preceding line, only when the next row is visible (next row < 480, including the wrap 524 -> 0);
  - no load pulses for g >= 80.
- enable low: no pixelclk, everything frozen; strobe phase resumes where it stopped.

Optional Feature:
TEST_PATTERN_EN.
- Defined: adds input port test_mode (1 bit). When test_mode = 1, visible pixels drive outputmuxsel = 10 instead of 01, and shift load pulses are suppressed. Blanking and sync are unchanged.
- Undefined: no test_mode port; outputmuxsel never equals 10.

Test Plan:
- Reset at t = 0, release on a falling edge; next posedge -> n_vsync_delay = 1, n_hsync_delay = 1, shiftmux_delay = 0, outputmuxsel = 00, colcount = 0.
- Free run of 6 clks after release -> exactly one pixelclk pulse. pixel_clk is high 3 clks, low 3 clks.
- Run one line (4800 clks) -> n_hsync_delay low for exactly 96 strobes, starting one strobe after col = 656; rowtimerenable pulses once, at col 799.
- Run a full frame -> flag_addr pulses once; addrcount ends at 307199, then resets to 0 at frame wrap; n_vsync_delay low for 2 lines.
- Line 0 -> shift1load at col 792 of the previous line and at 8, 24, ...; shift2load at 0, 16, ...; shiftmux_delay toggles every 8 pixels.
- Mid-frame reset (~167 us in) -> all outputs return to reset values asynchronously; counting restarts from 0 after release.
